// File: rtl/cache_read_arbiter.sv
// rtl/cache_read_arbiter.sv - NUM_MASTER-to-1 CacheBus read-path arbiter with id-based R routing
//
// Purpose: round-robin arbitration of upstream AR requests into a one-entry
// registered output stage, id widening with the master index, combinational
// R routing back by that index, and a per-master outstanding-burst limit.
// Optional build macro: CACHE_RARB_QOS_EN (master 0 gets strict priority).
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   s_ar_valid/s_ar/s_ar_ready   per-master AR channel (payload packed, id at MSBs)
//   s_r_valid/s_r/s_r_ready      per-master R valid/ready, broadcast R payload
//   m_ar_valid/m_ar/m_ar_ready   downstream AR channel, id = {master, id}
//   m_r_valid/m_r/m_r_ready      downstream R channel
//   err_route                    sticky: R beat carried a master index >= NUM_MASTER
//
// AR payload layout (MSB..LSB): id, addr, len[7:0], size[2:0], burst[1:0], user, snoop[3:0]
// R payload layout  (MSB..LSB): id, data, resp[1:0], last, user
module cache_read_arbiter #(
    parameter int NUM_MASTER      = 3,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int ID_WIDTH        = 2,
    parameter int USER_WIDTH      = 1,
    parameter int MAX_OUTSTANDING = 4,
    localparam int MW    = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1,
    localparam int DID   = ID_WIDTH + MW,
    localparam int AR_PW = ADDR_WIDTH + 8 + 3 + 2 + USER_WIDTH + 4,
    localparam int AR_UW = ID_WIDTH + AR_PW,
    localparam int AR_DW = DID + AR_PW,
    localparam int R_PW  = DATA_WIDTH + 2 + 1 + USER_WIDTH,
    localparam int R_UW  = ID_WIDTH + R_PW,
    localparam int R_DW  = DID + R_PW
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_MASTER-1:0]               s_ar_valid,
    input  logic [NUM_MASTER-1:0][AR_UW-1:0]    s_ar,
    output logic [NUM_MASTER-1:0]               s_ar_ready,
    output logic [NUM_MASTER-1:0]               s_r_valid,
    output logic [R_UW-1:0]                     s_r,
    input  logic [NUM_MASTER-1:0]               s_r_ready,
    output logic                                m_ar_valid,
    output logic [AR_DW-1:0]                    m_ar,
    input  logic                                m_ar_ready,
    input  logic                                m_r_valid,
    input  logic [R_DW-1:0]                     m_r,
    output logic                                m_r_ready,
    output logic                                err_route
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

`ifdef CACHE_RARB_QOS_EN
    localparam bit QOS = 1'b1;
`else
    localparam bit QOS = 1'b0;
`endif

    logic [CW-1:0]          cnt [NUM_MASTER];
    logic [MW-1:0]          rr_ptr;
    logic [AR_DW-1:0]       m_ar_q;
    logic                   m_ar_valid_q;
    logic                   err_q;

    logic [NUM_MASTER-1:0]  elig;
    logic [NUM_MASTER-1:0]  elig_rr;
    logic                   gnt_found;
    logic [MW-1:0]          gnt_idx;
    logic [MW-1:0]          gnt_next;
    logic                   accept;
    logic                   ar_hs;
    int                     scan;

    logic [MW-1:0]          r_idx;
    logic                   r_last;
    logic                   r_bad;
    logic                   r_rdy_sel;
    logic                   r_hs;
    logic [NUM_MASTER-1:0]  r_dec;

    assign accept = !m_ar_valid_q || m_ar_ready;

    always_comb begin
        for (int i = 0; i < NUM_MASTER; i++) begin
            elig[i] = s_ar_valid[i] && (cnt[i] < CW'(MAX_OUTSTANDING));
        end
        elig_rr = elig;
        // With priority enabled master 0 is taken out of the rotation entirely.
        if (QOS) elig_rr[0] = 1'b0;
    end

    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan      = 0;
        if (QOS && elig[0]) begin
            gnt_found = 1'b1;
        end else begin
            for (int k = 0; k < NUM_MASTER; k++) begin
                scan = (int'(rr_ptr) + k) % NUM_MASTER;
                if (!gnt_found && elig_rr[scan]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = MW'(scan);
                end
            end
        end
    end

    assign ar_hs    = accept && gnt_found;
    assign gnt_next = (int'(gnt_idx) == NUM_MASTER - 1) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        for (int i = 0; i < NUM_MASTER; i++) begin
            s_ar_ready[i] = ar_hs && (gnt_idx == MW'(i));
        end
    end

    // R routing: the master index rides in the top MW id bits.
    assign r_idx  = m_r[R_DW-1 -: MW];
    assign r_last = m_r[USER_WIDTH];
    assign r_bad  = ({1'b0, r_idx} >= (MW+1)'(NUM_MASTER));
    assign s_r    = m_r[R_UW-1:0];

    always_comb begin
        r_rdy_sel = 1'b0;
        for (int i = 0; i < NUM_MASTER; i++) begin
            s_r_valid[i] = m_r_valid && !r_bad && (r_idx == MW'(i));
            if (r_idx == MW'(i)) r_rdy_sel = s_r_ready[i];
        end
    end

    // Beats with an unroutable index are swallowed so the downstream never stalls.
    assign m_r_ready = r_bad || r_rdy_sel;
    assign r_hs      = m_r_valid && m_r_ready;

    always_comb begin
        for (int i = 0; i < NUM_MASTER; i++) begin
            r_dec[i] = r_hs && r_last && !r_bad && (r_idx == MW'(i));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_ar_valid_q <= 1'b0;
            m_ar_q       <= '0;
            rr_ptr       <= '0;
            err_q        <= 1'b0;
            for (int i = 0; i < NUM_MASTER; i++) cnt[i] <= '0;
        end else begin
            if (ar_hs) begin
                m_ar_q       <= {gnt_idx, s_ar[gnt_idx]};
                m_ar_valid_q <= 1'b1;
                // A priority grant to master 0 must not disturb the rotation of the others.
                if (!(QOS && gnt_idx == '0)) rr_ptr <= gnt_next;
            end else if (m_ar_ready) begin
                m_ar_valid_q <= 1'b0;
            end

            if (r_hs && r_bad) err_q <= 1'b1;

            for (int i = 0; i < NUM_MASTER; i++) begin
                if (s_ar_ready[i] && !r_dec[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (r_dec[i] && !s_ar_ready[i] && cnt[i] != '0) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    assign m_ar_valid = m_ar_valid_q;
    assign m_ar       = m_ar_q;
    assign err_route  = err_q;

endmodule

// File: tb/tb_cache_read_arbiter.sv
// tb/tb_cache_read_arbiter.sv - directed table-driven bench for cache_read_arbiter (MAX_OUTSTANDING=2)
module tb_cache_read_arbiter;

    localparam int NM = 3;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [NM-1:0]        s_ar_valid = '0;
    logic [NM-1:0][51:0]  s_ar;
    logic [NM-1:0]        s_ar_ready;
    logic [NM-1:0]        s_r_valid;
    logic [69:0]          s_r;
    logic [NM-1:0]        s_r_ready = '0;
    logic                 m_ar_valid;
    logic [53:0]          m_ar;
    logic                 m_ar_ready = 1'b0;
    logic                 m_r_valid = 1'b0;
    logic [71:0]          m_r = '0;
    logic                 m_r_ready;
    logic                 err_route;

    int checks = 0;
    int errors = 0;

    cache_read_arbiter #(
        .NUM_MASTER(NM), .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(2),
        .USER_WIDTH(1), .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk), .rst(rst),
        .s_ar_valid(s_ar_valid), .s_ar(s_ar), .s_ar_ready(s_ar_ready),
        .s_r_valid(s_r_valid), .s_r(s_r), .s_r_ready(s_r_ready),
        .m_ar_valid(m_ar_valid), .m_ar(m_ar), .m_ar_ready(m_ar_ready),
        .m_r_valid(m_r_valid), .m_r(m_r), .m_r_ready(m_r_ready),
        .err_route(err_route)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sv;
        logic       mrdy;
        logic       rv;
        logic [3:0] rid;
        logic       rlast;
        logic [2:0] srr;
        logic [2:0] e_sar;
        logic       e_mav;
        logic [3:0] e_maid;
        logic [2:0] e_srv;
        logic       e_mrr;
        logic       e_err;
    } vec_t;

    vec_t vt [19];

    function automatic vec_t mk(logic [2:0] sv, logic mrdy, logic rv, logic [3:0] rid,
                                logic rlast, logic [2:0] srr, logic [2:0] e_sar,
                                logic e_mav, logic [3:0] e_maid, logic [2:0] e_srv,
                                logic e_mrr, logic e_err);
        vec_t v;
        v.sv = sv; v.mrdy = mrdy; v.rv = rv; v.rid = rid; v.rlast = rlast; v.srr = srr;
        v.e_sar = e_sar; v.e_mav = e_mav; v.e_maid = e_maid; v.e_srv = e_srv;
        v.e_mrr = e_mrr; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive_r(input logic rv, input logic [3:0] rid, input logic rlast);
        m_r_valid = rv;
        m_r = {rid, 64'hA5A5_0000_0000_0000 | 64'(rid), 2'b00, rlast, 1'b0};
    endtask

    // Master i: upstream id i+1, addr i<<12, len 3, size 3, burst INCR.
    initial begin
        for (int i = 0; i < NM; i++) begin
            s_ar[i] = {2'(i + 1), 32'(i << 12), 8'd3, 3'd3, 2'd1, 1'b0, 4'd0};
        end
    end

    initial begin
        //           sv     rdy rv rid  lst srr     e_sar  mav maid e_srv  mrr err
        vt[0]  = mk(3'b111, 1, 0, 4'd0, 0, 3'b000, 3'b001, 0, 4'd0,  3'b000, 0, 0);
        vt[1]  = mk(3'b111, 1, 0, 4'd0, 0, 3'b000, 3'b010, 1, 4'd1,  3'b000, 0, 0);
        vt[2]  = mk(3'b111, 1, 0, 4'd0, 0, 3'b000, 3'b100, 1, 4'd6,  3'b000, 0, 0);
        vt[3]  = mk(3'b111, 1, 0, 4'd0, 0, 3'b000, 3'b001, 1, 4'd11, 3'b000, 0, 0);
        vt[4]  = mk(3'b111, 1, 0, 4'd0, 0, 3'b000, 3'b010, 1, 4'd1,  3'b000, 0, 0);
        vt[5]  = mk(3'b111, 1, 0, 4'd0, 0, 3'b000, 3'b100, 1, 4'd6,  3'b000, 0, 0);
        vt[6]  = mk(3'b111, 1, 0, 4'd0, 0, 3'b000, 3'b000, 1, 4'd11, 3'b000, 0, 0);
        vt[7]  = mk(3'b111, 1, 1, 4'd1, 1, 3'b001, 3'b000, 0, 4'd0,  3'b001, 1, 0);
        vt[8]  = mk(3'b111, 1, 0, 4'd0, 0, 3'b000, 3'b001, 0, 4'd0,  3'b000, 0, 0);
        vt[9]  = mk(3'b111, 1, 0, 4'd0, 0, 3'b000, 3'b000, 1, 4'd1,  3'b000, 0, 0);
        vt[10] = mk(3'b100, 1, 1, 4'd9, 0, 3'b100, 3'b000, 0, 4'd0,  3'b100, 1, 0);
        vt[11] = mk(3'b100, 1, 1, 4'd9, 0, 3'b000, 3'b000, 0, 4'd0,  3'b100, 0, 0);
        vt[12] = mk(3'b100, 1, 1, 4'd9, 0, 3'b100, 3'b000, 0, 4'd0,  3'b100, 1, 0);
        vt[13] = mk(3'b100, 1, 1, 4'd9, 0, 3'b100, 3'b000, 0, 4'd0,  3'b100, 1, 0);
        vt[14] = mk(3'b100, 1, 1, 4'd9, 1, 3'b100, 3'b000, 0, 4'd0,  3'b100, 1, 0);
        vt[15] = mk(3'b100, 1, 0, 4'd0, 0, 3'b000, 3'b100, 0, 4'd0,  3'b000, 0, 0);
        vt[16] = mk(3'b000, 1, 1, 4'd14,1, 3'b000, 3'b000, 1, 4'd11, 3'b000, 1, 0);
        vt[17] = mk(3'b000, 1, 0, 4'd0, 0, 3'b000, 3'b000, 0, 4'd0,  3'b000, 0, 1);
        vt[18] = mk(3'b000, 1, 0, 4'd0, 0, 3'b000, 3'b000, 0, 4'd0,  3'b000, 0, 1);

        drive_r(1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_m_ar_valid", 64'(m_ar_valid), 64'd0);
        chk("reset_m_ar", 64'(m_ar), 64'd0);
        chk("reset_err_route", 64'(err_route), 64'd0);
        @(negedge clk);
        rst = 1'b1;

`ifndef CACHE_RARB_QOS_EN
        for (int n = 0; n < 19; n++) begin
            @(negedge clk);
            s_ar_valid = vt[n].sv;
            m_ar_ready = vt[n].mrdy;
            s_r_ready  = vt[n].srr;
            drive_r(vt[n].rv, vt[n].rid, vt[n].rlast);
            #1;
            chk($sformatf("v%0d_s_ar_ready", n), 64'(s_ar_ready), 64'(vt[n].e_sar));
            chk($sformatf("v%0d_m_ar_valid", n), 64'(m_ar_valid), 64'(vt[n].e_mav));
            if (vt[n].e_mav) chk($sformatf("v%0d_m_ar_id", n), 64'(m_ar[53:50]), 64'(vt[n].e_maid));
            chk($sformatf("v%0d_s_r_valid", n), 64'(s_r_valid), 64'(vt[n].e_srv));
            chk($sformatf("v%0d_m_r_ready", n), 64'(m_r_ready), 64'(vt[n].e_mrr));
            chk($sformatf("v%0d_err_route", n), 64'(err_route), 64'(vt[n].e_err));
            chk($sformatf("v%0d_s_r_id", n), 64'(s_r[69:68]), 64'(vt[n].rid & 4'h3));
        end
`endif

        // Reset clears the sticky error.
        @(negedge clk);
        s_ar_valid = '0; s_r_ready = '0; m_ar_ready = 1'b1;
        drive_r(1'b0, 4'd0, 1'b0);
        rst = 1'b0;
        #1;
        chk("rst_err_clear", 64'(err_route), 64'd0);
        chk("rst_mav_clear", 64'(m_ar_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Backpressure: master 1 wins, then downstream stalls 5 cycles.
        @(negedge clk);
        s_ar_valid = 3'b010;
        #1;
        chk("bp_first_grant", 64'(s_ar_ready), 64'b010);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            s_ar_valid = 3'b111;
            m_ar_ready = 1'b0;
            #1;
            chk($sformatf("bp%0d_valid", c), 64'(m_ar_valid), 64'd1);
            chk($sformatf("bp%0d_addr", c), 64'(m_ar[49:18]), 64'h1000);
            chk($sformatf("bp%0d_id", c), 64'(m_ar[53:50]), 64'd6);
            chk($sformatf("bp%0d_ready", c), 64'(s_ar_ready), 64'd0);
        end
        @(negedge clk);
        m_ar_ready = 1'b1;
        #1;
`ifdef CACHE_RARB_QOS_EN
        chk("bp_release_grant", 64'(s_ar_ready), 64'b001);
`else
        chk("bp_release_grant", 64'(s_ar_ready), 64'b100);
`endif
        chk("bp_release_addr", 64'(m_ar[49:18]), 64'h1000);

        // Asynchronous reset while the output stage is full.
        @(negedge clk);
        s_ar_valid = '0;
        #1;
`ifdef CACHE_RARB_QOS_EN
        chk("mid_id_before_rst", 64'(m_ar[53:50]), 64'd1);
`else
        chk("mid_id_before_rst", 64'(m_ar[53:50]), 64'd11);
`endif
        rst = 1'b0;
        #1;
        chk("mid_rst_mav_drop", 64'(m_ar_valid), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Master 1 had one burst in flight before reset; two more must fit now.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            s_ar_valid = 3'b010;
            #1;
            chk($sformatf("post_rst_grant%0d", c), 64'(s_ar_ready), (c < 2) ? 64'b010 : 64'b000);
        end

`ifdef CACHE_RARB_QOS_EN
        @(negedge clk);
        s_ar_valid = '0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        s_ar_valid = 3'b011;
        #1;
        chk("qos_first", 64'(s_ar_ready), 64'b001);
        // Retire one master-0 burst each cycle so its count stays at 1.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            s_r_ready = 3'b001;
            drive_r(1'b1, 4'd1, 1'b1);
            #1;
            chk($sformatf("qos_m0_wins%0d", c), 64'(s_ar_ready), 64'b001);
            chk($sformatf("qos_mrr%0d", c), 64'(m_r_ready), 64'd1);
        end
        @(negedge clk);
        drive_r(1'b0, 4'd0, 1'b0);
        s_ar_valid = 3'b010;
        #1;
        chk("qos_m1_after", 64'(s_ar_ready), 64'b010);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_read_arbiter.md
Name: cache_read_arbiter

Overview:
- Shares one downstream CacheBus read path (AR + R channels) between NUM_MASTER upstream read masters, e.g. icache, dcache and ptw, in front of the L2/interconnect port.
- Arbitrates AR round-robin and registers the winner into a one-entry output stage.
- Widens the AR id with the master index and routes R beats back by that index.
- Enforces a per-master outstanding-read limit.

Parameters:
- NUM_MASTER, 3, number of upstream read masters (2..8).
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 64, R data width.
- ID_WIDTH, 2, upstream id width.
- USER_WIDTH, 1, user width.
- MAX_OUTSTANDING, 4, max in-flight bursts per master (1..15).
- Derived: MW = $clog2(NUM_MASTER), minimum 1.
- Derived: downstream id width DID = ID_WIDTH+MW.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-low.
- s_ar_valid  in  NUM_MASTER  per-master AR valid.
- s_ar  in  NUM_MASTER x ar_chan_t(ID_WIDTH)  per-master AR payload (id, addr, len, size, burst, user, snoop[3:0]).
- s_ar_ready  out  NUM_MASTER  per-master AR ready.
- s_r_valid  out  NUM_MASTER  per-master R valid.
- s_r  out  r_chan_t(ID_WIDTH)  R payload broadcast to all masters.
- s_r_ready  in  NUM_MASTER  per-master R ready.
- m_ar_valid  out  1  downstream AR valid.
- m_ar  out  ar_chan_t(DID)  downstream AR payload.
- m_ar_ready  in  1  downstream AR ready.
- m_r_valid  in  1  downstream R valid.
- m_r  in  r_chan_t(DID)  downstream R payload.
- m_r_ready  out  1  downstream R ready.
- err_route  out  1  sticky: R beat received with master index >= NUM_MASTER.

Behaviour:
- Reset values (rst low, asynchronous): m_ar_valid=0, m_ar=0, all outstanding counters=0, rr_ptr=0, err_route=0. All other outputs are combinational and follow from this state.
- Eligibility: master i is eligible when s_ar_valid[i] && cnt[i] < MAX_OUTSTANDING.
- Output stage is a single register. accept = !m_ar_valid || m_ar_ready, so back-to-back grants are possible at full throughput.
- Grant: when accept=1, pick the first eligible master scanning rr_ptr, rr_ptr+1, ... wrapping modulo NUM_MASTER.
  - s_ar_ready[g]=1 for the granted master only; all other s_ar_ready=0.
  - s_ar_ready depends on s_ar_valid, which AXI permits for ready.
- Load on handshake: m_ar <= s_ar[g] with id = {g[MW-1:0], s_ar[g].id}; m_ar_valid <= 1; rr_ptr <= (g+1) mod NUM_MASTER.
- No eligible master while accept=1 and m_ar_ready=1: m_ar_valid <= 0. rr_ptr is unchanged when there is no grant.
- AR latency is exactly 1 cycle: upstream handshake at cycle t, m_ar_valid=1 at t+1. m_ar is held stable while m_ar_valid && !m_ar_ready.
- R routing is combinational, zero latency.
  - idx = m_r.id[DID-1:ID_WIDTH]; s_r = m_r with id truncated to the low ID_WIDTH bits.
  - s_r_valid[idx] = m_r_valid; m_r_ready = s_r_ready[idx].
  - If idx >= NUM_MASTER: m_r_ready=1 (beat dropped), no s_r_valid, err_route <= 1 on the handshake. err_route clears only on reset.
- Counters:
  - cnt[i]++ on upstream AR handshake of i.
  - cnt[i]-- on an R handshake with idx=i and m_r.last=1.
  - Both in the same cycle: unchanged.
  - Decrement at 0 never happens for legal traffic; saturate at 0.
  - Counter width is $clog2(MAX_OUTSTANDING+1).
- Full: cnt[i]==MAX_OUTSTANDING makes i ineligible and arbitration skips it. A last-beat decrement in cycle t makes i eligible in cycle t+1, not combinationally.
- Single master: MW=1 and the prepended id bit is 0.
- Reset mid-burst: all state clears immediately. Downstream must also be reset, since in-flight bursts are forgotten.

Optional Feature:
- Macro: CACHE_RARB_QOS_EN.
- Defined: master 0 has strict priority. If master 0 is eligible it wins regardless of rr_ptr, and rr_ptr is not updated on a master-0 grant. Masters 1..N-1 round-robin among themselves when master 0 is not eligible.
- Undefined: pure round-robin over all masters as above.

Test Plan:
- Contention. Masters 0,1,2 all valid continuously, m_ar_ready=1, MAX_OUTSTANDING large.
  - Grants 0,1,2,0,1,2 on consecutive cycles.
  - m_ar.id high bits 0,1,2 appear one cycle after each upstream handshake.
- Backpressure. m_ar_ready=0 for 5 cycles after the first grant of master 1 (addr 0x1000).
  - m_ar holds addr 0x1000 and id {1,x} stable.
  - s_ar_ready is all 0 until m_ar_ready=1.
- Outstanding limit. MAX_OUTSTANDING=2, master 0 issues 3 ARs, no R returned.
  - Third AR is not accepted. Master 1 is still granted.
  - After an R beat with last=1 and id {0,*}, master 0's third AR is accepted the next cycle.
- R routing. Downstream returns a 4-beat burst id={2,2'b01}, s_r_ready[2] toggled 1,0,1,1,1.
  - Only s_r_valid[2] is asserted, with s_r.id=1.
  - m_r_ready mirrors s_r_ready[2].
  - cnt[2] decrements only on the last handshake.
- Bad id. m_r.id high bits=3 with NUM_MASTER=3.
  - m_r_ready=1, no s_r_valid, err_route=1 next cycle and stays 1.
- Reset and QoS. Assert rst low mid-traffic: m_ar_valid drops to 0 immediately and counters read 0. With CACHE_RARB_QOS_EN and masters 0 and 1 continuously valid: master 0 wins every cycle and master 1 is never granted until master 0 deasserts.
